ddr_rd_arbiter: RTL and testbench
=================================

// Module: ddr_rd_arbiter
// PURPOSE
//  Shares the single AXI read master (RSTART_REG/RADDR_REG/RNBURST_REG/RDONE_REG) between two
//  load requesters: weight loader (WEI, req 0) and feature-map loader (FTM, req 1). Splits each
//  request into chunks of <= UNIT_BURSTS bursts and re-arbitrates between chunks, so long loads interleave.
//  Drives rd_sel so the downstream stream demux routes read data to the owning buffer.
// PARAMETERS
//  UNIT_BURSTS      16   max bursts per issued chunk (power of 2)
//  BYTES_PER_BURST  128  bytes per burst (16 x 64-bit beats); address stride per burst
//  NB_W             25   width of request burst count
// PORTS
//  clk            in   1     clock
//  rstn           in   1     reset; asynchronous, active-low
//  wei_req_valid  in   1     WEI request pending (hold until accepted)
//  wei_req_ready  out  1     WEI request accepted this cycle (valid&ready)
//  wei_req_addr   in   32    WEI start byte address
//  wei_req_nburst in   NB_W  WEI total bursts (0 is illegal, ignored: accepted then done)
//  wei_hold       in   1     WEI buffer full: do not issue next WEI chunk
//  wei_done       out  1     1-cycle pulse: last WEI chunk completed
//  ftm_*          -    -     same six ports for FTM
//  RSTART_REG     out  1     start to read master
//  RADDR_REG      out  32    chunk byte address
//  RNBURST_REG    out  32    chunk burst count (zero-extended)
//  RDONE_REG      in   1     master idle/end (level)
//  rd_sel         out  1     owner of current chunk: 0=WEI, 1=FTM
//  busy           out  1     any request accepted and not finished
// BEHAVIOUR
//  Reset: all outputs 0; both contexts empty; last_grant=FTM (so WEI wins first tie); state IDLE.
//  Per-requester context: act, addr_r, rema_r. Accept when ctx empty & valid: ready=1 one cycle,
//   addr_r<=addr, rema_r<=nburst, act<=1. Accept of both in same cycle permitted.
//  nburst==0: accept, then wei_done/ftm_done pulse next cycle, no master traffic.
//  Eligible(r) = act & ~hold(r). Round-robin: both eligible -> grant != last_grant.
//  FSM:
//   IDLE  : any eligible -> ARB.
//   ARB   : latch grant g, chunk n=min(rema,UNIT_BURSTS), rd_sel<=g -> START.
//   START : RSTART_REG=1, RADDR=addr_r[g], RNBURST=n; stay until RDONE_REG seen 0 -> WAIT.
//   WAIT  : RSTART_REG=0; on RDONE_REG=1 -> UPD.
//   UPD   : addr_r[g]+=n*BYTES_PER_BURST (shift, 32-bit wrap); rema_r[g]-=n;
//           if rema reaches 0: act<=0, done(g) pulse; last_grant<=g -> IDLE.
//  Latency: valid->RSTART 3 cycles when master idle (accept, IDLE, ARB).
//  RADDR_REG/RNBURST_REG stable from START to WAIT exit; 0 in other states.
//  hold asserted mid-chunk: no effect on the chunk in flight; only gates next ARB.
//  Both held: stay IDLE, busy=1. New request accepted while other chunk in flight: allowed.
//  rd_sel changes only in ARB, never during START/WAIT.
//  Async reset mid-chunk drops contexts; master must be reset by the same rstn.
// CONFIGURATION
//  DDR_ARB_STATS_EN defined: adds outputs stat_wei_bursts, stat_ftm_bursts (32-bit, += n in UPD,
//   saturating) and stat_stall_cycles (32-bit, counts cycles act&hold with no eligible req).
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package ddr_arb_pkg: state enum (IDLE,ARB,START,WAIT,UPD), REQ_WEI=0/REQ_FTM=1,
//   BURST_SHIFT=$clog2(BYTES_PER_BURST), UNIT_BURSTS default.
//  One sub-module: ddr_arb_req_ctx (per-requester accept/addr/remaining/done), instantiated x2.
// TESTING
//  1 WEI only, addr=0x1000, nburst=40, master done 5 cycles after start -> chunks (0x1000,16),
//    (0x1800,16),(0x2000,8); one wei_done after third; rd_sel=0 throughout.
//  2 WEI nburst=32 and FTM nburst=32 valid same cycle -> issue order WEI,FTM,WEI,FTM;
//    rd_sel toggles 0,1,0,1; both dones, WEI first.
//  3 WEI active, wei_hold=1 after first chunk, FTM nburst=16 -> FTM chunk issued next;
//    no WEI RSTART until hold drops; resumes at addr+0x800.
//  4 FTM nburst=0 -> ftm_req_ready then ftm_done next cycle, RSTART_REG never asserted.
//  5 rstn low during WAIT -> all outputs 0 immediately; after release new WEI req issues normally.
//  6 addr=0xFFFF_F800, nburst=32 -> second chunk RADDR=0x0000_0000 (wrap); [STATS_EN] stat_wei_bursts=32.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR read arbiter.
// A saturating adder is provided for the optional DDR_ARB_STATS_EN counters.
package ddr_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        START,
        WAIT,
        UPD
    } arb_state_t;

    localparam logic REQ_WEI = 1'b0;
    localparam logic REQ_FTM = 1'b1;

    localparam int DEF_UNIT_BURSTS     = 16;
    localparam int DEF_BYTES_PER_BURST = 128;
    localparam int BURST_SHIFT         = $clog2(DEF_BYTES_PER_BURST);

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/ddr_arb_req_ctx.sv
// Per-requester load context: accepts one request, tracks next chunk address
// and remaining bursts, and pulses done when the request is fully served.
module ddr_arb_req_ctx
    import ddr_arb_pkg::*;
#(
    parameter int NB_W  = 25,
    parameter int CNT_W = 5,
    parameter int SHIFT = BURST_SHIFT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [NB_W-1:0]  req_nburst,
    input  logic             consume,
    input  logic [CNT_W-1:0] consume_n,
    output logic             act,
    output logic [31:0]      addr,
    output logic [NB_W-1:0]  rema,
    output logic             done
);

    logic [31:0] step;

    assign req_ready = req_valid & ~act;
    assign step      = 32'(consume_n) << SHIFT;

    // A zero-length request is acknowledged and retired without ever becoming active.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act  <= 1'b0;
            addr <= '0;
            rema <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (req_ready) begin
                addr <= req_addr;
                rema <= req_nburst;
                if (req_nburst == '0) begin
                    done <= 1'b1;
                end else begin
                    act <= 1'b1;
                end
            end else if (consume && act) begin
                addr <= addr + step;
                rema <= rema - NB_W'(consume_n);
                if (rema == NB_W'(consume_n)) begin
                    act  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin chunked arbiter sharing one AXI read master between WEI and FTM loaders.
// Optional statistics outputs are enabled with `define DDR_ARB_STATS_EN.
module ddr_rd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int UNIT_BURSTS     = DEF_UNIT_BURSTS,
    parameter int BYTES_PER_BURST = DEF_BYTES_PER_BURST,
    parameter int NB_W            = 25
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            wei_req_valid,
    output logic            wei_req_ready,
    input  logic [31:0]     wei_req_addr,
    input  logic [NB_W-1:0] wei_req_nburst,
    input  logic            wei_hold,
    output logic            wei_done,

    input  logic            ftm_req_valid,
    output logic            ftm_req_ready,
    input  logic [31:0]     ftm_req_addr,
    input  logic [NB_W-1:0] ftm_req_nburst,
    input  logic            ftm_hold,
    output logic            ftm_done,

    output logic            RSTART_REG,
    output logic [31:0]     RADDR_REG,
    output logic [31:0]     RNBURST_REG,
    input  logic            RDONE_REG,

    output logic            rd_sel,
`ifdef DDR_ARB_STATS_EN
    output logic [31:0]     stat_wei_bursts,
    output logic [31:0]     stat_ftm_bursts,
    output logic [31:0]     stat_stall_cycles,
`endif
    output logic            busy
);

    localparam int CNT_W = $clog2(UNIT_BURSTS) + 1;
    localparam int SHIFT = $clog2(BYTES_PER_BURST);

    arb_state_t state_r, state_nx;

    logic             wei_act, ftm_act;
    logic [31:0]      wei_addr, ftm_addr;
    logic [NB_W-1:0]  wei_rema, ftm_rema;
    logic [CNT_W-1:0] wei_n, ftm_n;
    logic             wei_consume, ftm_consume;
    logic             wei_elig, ftm_elig, any_elig;
    logic             grant_c, grant_r, last_grant_r;
    logic [CNT_W-1:0] n_r;
    logic [31:0]      chunk_addr_r;
    logic             in_chunk;

    ddr_arb_req_ctx #(.NB_W(NB_W), .CNT_W(CNT_W), .SHIFT(SHIFT)) u_wei_ctx (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (wei_req_valid),
        .req_ready  (wei_req_ready),
        .req_addr   (wei_req_addr),
        .req_nburst (wei_req_nburst),
        .consume    (wei_consume),
        .consume_n  (n_r),
        .act        (wei_act),
        .addr       (wei_addr),
        .rema       (wei_rema),
        .done       (wei_done)
    );

    ddr_arb_req_ctx #(.NB_W(NB_W), .CNT_W(CNT_W), .SHIFT(SHIFT)) u_ftm_ctx (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (ftm_req_valid),
        .req_ready  (ftm_req_ready),
        .req_addr   (ftm_req_addr),
        .req_nburst (ftm_req_nburst),
        .consume    (ftm_consume),
        .consume_n  (n_r),
        .act        (ftm_act),
        .addr       (ftm_addr),
        .rema       (ftm_rema),
        .done       (ftm_done)
    );

    assign wei_n = (wei_rema >= NB_W'(UNIT_BURSTS)) ? CNT_W'(UNIT_BURSTS) : wei_rema[CNT_W-1:0];
    assign ftm_n = (ftm_rema >= NB_W'(UNIT_BURSTS)) ? CNT_W'(UNIT_BURSTS) : ftm_rema[CNT_W-1:0];

    assign wei_elig = wei_act & ~wei_hold;
    assign ftm_elig = ftm_act & ~ftm_hold;
    assign any_elig = wei_elig | ftm_elig;

    // On a tie the requester that did not own the previous chunk wins.
    assign grant_c = (wei_elig && ftm_elig) ? ~last_grant_r : ftm_elig;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            grant_r      <= REQ_WEI;
            last_grant_r <= REQ_FTM;
            rd_sel       <= REQ_WEI;
            n_r          <= '0;
            chunk_addr_r <= '0;
        end else begin
            state_r <= state_nx;
            if (state_r == ARB && any_elig) begin
                grant_r      <= grant_c;
                rd_sel       <= grant_c;
                n_r          <= (grant_c == REQ_FTM) ? ftm_n : wei_n;
                chunk_addr_r <= (grant_c == REQ_FTM) ? ftm_addr : wei_addr;
            end
            if (state_r == UPD) begin
                last_grant_r <= grant_r;
            end
        end
    end

    // Hold may rise between IDLE and ARB, so ARB re-checks eligibility before committing.
    always_comb begin
        state_nx    = state_r;
        RSTART_REG  = 1'b0;
        wei_consume = 1'b0;
        ftm_consume = 1'b0;
        case (state_r)
            IDLE:  if (any_elig) state_nx = ARB;
            ARB:   state_nx = any_elig ? START : IDLE;
            START: begin
                RSTART_REG = 1'b1;
                if (!RDONE_REG) state_nx = WAIT;
            end
            WAIT:  if (RDONE_REG) state_nx = UPD;
            UPD: begin
                wei_consume = (grant_r == REQ_WEI);
                ftm_consume = (grant_r == REQ_FTM);
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign in_chunk    = (state_r == START) || (state_r == WAIT);
    assign RADDR_REG   = in_chunk ? chunk_addr_r : 32'h0;
    assign RNBURST_REG = in_chunk ? 32'(n_r) : 32'h0;
    assign busy        = wei_act | ftm_act;

`ifdef DDR_ARB_STATS_EN
    logic stall;

    assign stall = ((wei_act & wei_hold) | (ftm_act & ftm_hold)) & ~any_elig;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_wei_bursts   <= '0;
            stat_ftm_bursts   <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (state_r == UPD && grant_r == REQ_WEI) begin
                stat_wei_bursts <= sat_add32(stat_wei_bursts, 32'(n_r));
            end
            if (state_r == UPD && grant_r == REQ_FTM) begin
                stat_ftm_bursts <= sat_add32(stat_ftm_bursts, 32'(n_r));
            end
            if (stall) begin
                stat_stall_cycles <= sat_add32(stat_stall_cycles, 32'd1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed scoreboard bench for ddr_rd_arbiter with a behavioural read-master model.
// Build with DDR_ARB_STATS_EN defined to also check the statistics outputs.
module tb_ddr_rd_arbiter;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] nb;
    } chunk_t;

    logic        clk;
    logic        rstn;
    logic        wei_req_valid, wei_req_ready, wei_hold, wei_done;
    logic [31:0] wei_req_addr;
    logic [24:0] wei_req_nburst;
    logic        ftm_req_valid, ftm_req_ready, ftm_hold, ftm_done;
    logic [31:0] ftm_req_addr;
    logic [24:0] ftm_req_nburst;
    logic        RSTART_REG, RDONE_REG, rd_sel, busy;
    logic [31:0] RADDR_REG, RNBURST_REG;
`ifdef DDR_ARB_STATS_EN
    logic [31:0] stat_wei_bursts, stat_ftm_bursts, stat_stall_cycles;
`endif

    int     n_checks = 0;
    int     n_fail   = 0;
    chunk_t exp_q[$];
    int     done_q[$];
    logic   m_busy   = 1'b0;
    int     m_cnt    = 0;
    int     n_starts = 0;
    chunk_t cur;

    ddr_rd_arbiter dut (
        .clk            (clk),
        .rstn           (rstn),
        .wei_req_valid  (wei_req_valid),
        .wei_req_ready  (wei_req_ready),
        .wei_req_addr   (wei_req_addr),
        .wei_req_nburst (wei_req_nburst),
        .wei_hold       (wei_hold),
        .wei_done       (wei_done),
        .ftm_req_valid  (ftm_req_valid),
        .ftm_req_ready  (ftm_req_ready),
        .ftm_req_addr   (ftm_req_addr),
        .ftm_req_nburst (ftm_req_nburst),
        .ftm_hold       (ftm_hold),
        .ftm_done       (ftm_done),
        .RSTART_REG     (RSTART_REG),
        .RADDR_REG      (RADDR_REG),
        .RNBURST_REG    (RNBURST_REG),
        .RDONE_REG      (RDONE_REG),
        .rd_sel         (rd_sel),
`ifdef DDR_ARB_STATS_EN
        .stat_wei_bursts   (stat_wei_bursts),
        .stat_ftm_bursts   (stat_ftm_bursts),
        .stat_stall_cycles (stat_stall_cycles),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Read-master model: accepts a start, drops RDONE, raises it again 5 cycles later.
    initial begin
        chunk_t e;
        RDONE_REG = 1'b1;
        forever begin
            @(negedge clk);
            if (!rstn) continue;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    check_output("raddr_stable", RADDR_REG, cur.addr);
                    check_output("rnburst_stable", RNBURST_REG, cur.nb);
                    check_output("rd_sel_stable", rd_sel, cur.sel);
                    check_output("rstart_low_in_wait", RSTART_REG, 1'b0);
                    RDONE_REG = 1'b1;
                    m_busy    = 1'b0;
                end
                m_cnt--;
            end else if (RSTART_REG) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                end else begin
                    e.sel  = 1'b0;
                    e.addr = 32'hDEAD_BEEF;
                    e.nb   = 32'h0;
                end
                check_output("chunk_sel", rd_sel, e.sel);
                check_output("chunk_addr", RADDR_REG, e.addr);
                check_output("chunk_nburst", RNBURST_REG, e.nb);
                cur       = e;
                n_starts++;
                RDONE_REG = 1'b0;
                m_busy    = 1'b1;
                m_cnt     = 5;
            end
        end
    end

    // Done monitor: every done pulse must match the next expected requester.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rstn && wei_done) begin
                e = (done_q.size() != 0) ? done_q.pop_front() : 9;
                check_output("wei_done_order", 64'd0, 64'(e));
            end
            if (rstn && ftm_done) begin
                e = (done_q.size() != 0) ? done_q.pop_front() : 9;
                check_output("ftm_done_order", 64'd1, 64'(e));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_rstart"}, RSTART_REG, 1'b0);
        check_output({tag, "_raddr"}, RADDR_REG, 32'h0);
        check_output({tag, "_rnburst"}, RNBURST_REG, 32'h0);
        check_output({tag, "_rd_sel"}, rd_sel, 1'b0);
        check_output({tag, "_busy"}, busy, 1'b0);
        check_output({tag, "_dones"}, {wei_done, ftm_done}, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn          = 1'b0;
        wei_req_valid = 1'b0;
        ftm_req_valid = 1'b0;
        wei_hold      = 1'b0;
        ftm_hold      = 1'b0;
        m_busy        = 1'b0;
        RDONE_REG     = 1'b1;
        exp_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic apply_stimulus(input logic w_v, input logic [31:0] w_a, input logic [24:0] w_n,
                                  input logic f_v, input logic [31:0] f_a, input logic [24:0] f_n);
        @(negedge clk);
        #1;
        wei_req_valid  = w_v;
        wei_req_addr   = w_a;
        wei_req_nburst = w_n;
        ftm_req_valid  = f_v;
        ftm_req_addr   = f_a;
        ftm_req_nburst = f_n;
        #1;
        if (w_v) check_output("wei_ready", wei_req_ready, 1'b1);
        if (f_v) check_output("ftm_ready", ftm_req_ready, 1'b1);
        @(posedge clk);
        #1;
        wei_req_valid = 1'b0;
        ftm_req_valid = 1'b0;
    endtask

    task automatic push_chunk(input logic sel, input logic [31:0] addr, input logic [31:0] nb);
        chunk_t c;
        c.sel  = sel;
        c.addr = addr;
        c.nb   = nb;
        exp_q.push_back(c);
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && done_q.size() == 0 && !m_busy && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_output(tag, ok, 1'b1);
    endtask

    initial begin
        int snap;
        logic ok;
        rstn           = 1'b0;
        wei_req_valid  = 1'b0;
        ftm_req_valid  = 1'b0;
        wei_hold       = 1'b0;
        ftm_hold       = 1'b0;
        wei_req_addr   = '0;
        wei_req_nburst = '0;
        ftm_req_addr   = '0;
        ftm_req_nburst = '0;
        #12;
        check_reset_outputs("reset");
        check_output("reset_readies", {wei_req_ready, ftm_req_ready}, 2'b00);

        $display("[TB] test 1: WEI only, 40 bursts");
        do_reset();
        push_chunk(1'b0, 32'h0000_1000, 32'd16);
        push_chunk(1'b0, 32'h0000_1800, 32'd16);
        push_chunk(1'b0, 32'h0000_2000, 32'd8);
        done_q.push_back(0);
        apply_stimulus(1'b1, 32'h0000_1000, 25'd40, 1'b0, 32'h0, 25'd0);
        check_output("t1_busy", busy, 1'b1);
        wait_quiet("t1_quiet", 400);

        $display("[TB] test 2: WEI and FTM together, round robin");
        do_reset();
        push_chunk(1'b0, 32'h0001_0000, 32'd16);
        push_chunk(1'b1, 32'h0002_0000, 32'd16);
        push_chunk(1'b0, 32'h0001_0800, 32'd16);
        push_chunk(1'b1, 32'h0002_0800, 32'd16);
        done_q.push_back(0);
        done_q.push_back(1);
        apply_stimulus(1'b1, 32'h0001_0000, 25'd32, 1'b1, 32'h0002_0000, 25'd32);
        wait_quiet("t2_quiet", 400);

        $display("[TB] test 3: WEI held after first chunk");
        do_reset();
        push_chunk(1'b0, 32'h0000_4000, 32'd16);
        apply_stimulus(1'b1, 32'h0000_4000, 25'd32, 1'b0, 32'h0, 25'd0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (n_starts > 0 && m_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("t3_first_start", ok, 1'b1);
        wei_hold = 1'b1;
        push_chunk(1'b1, 32'h0000_8000, 32'd16);
        done_q.push_back(1);
        apply_stimulus(1'b0, 32'h0, 25'd0, 1'b1, 32'h0000_8000, 25'd16);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && done_q.size() == 0 && !m_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("t3_ftm_served", ok, 1'b1);
        snap = n_starts;
        repeat (20) @(negedge clk);
        check_output("t3_no_start_while_held", 64'(n_starts), 64'(snap));
        check_output("t3_busy_held", busy, 1'b1);
        push_chunk(1'b0, 32'h0000_4800, 32'd16);
        done_q.push_back(0);
        wei_hold = 1'b0;
        wait_quiet("t3_quiet", 200);

        $display("[TB] test 4: FTM zero-length request");
        do_reset();
        snap = n_starts;
        done_q.push_back(1);
        apply_stimulus(1'b0, 32'h0, 25'd0, 1'b1, 32'h0000_C000, 25'd0);
        check_output("t4_ftm_done_next", ftm_done, 1'b1);
        wait_quiet("t4_quiet", 20);
        repeat (5) @(negedge clk);
        check_output("t4_no_rstart", 64'(n_starts), 64'(snap));

        $display("[TB] test 5: reset during WAIT");
        do_reset();
        push_chunk(1'b1, 32'h0003_0000, 32'd16);
        apply_stimulus(1'b0, 32'h0, 25'd0, 1'b1, 32'h0003_0000, 25'd16);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (m_busy && m_cnt == 3) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("t5_in_wait", ok, 1'b1);
        check_output("t5_rd_sel_before", rd_sel, 1'b1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        m_busy    = 1'b0;
        RDONE_REG = 1'b1;
        exp_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        push_chunk(1'b0, 32'h0000_0100, 32'd16);
        done_q.push_back(0);
        apply_stimulus(1'b1, 32'h0000_0100, 25'd16, 1'b0, 32'h0, 25'd0);
        wait_quiet("t5_quiet", 200);

        $display("[TB] test 6: address wrap");
        do_reset();
        push_chunk(1'b0, 32'hFFFF_F800, 32'd16);
        push_chunk(1'b0, 32'h0000_0000, 32'd16);
        done_q.push_back(0);
        apply_stimulus(1'b1, 32'hFFFF_F800, 25'd32, 1'b0, 32'h0, 25'd0);
        wait_quiet("t6_quiet", 300);
`ifdef DDR_ARB_STATS_EN
        check_output("t6_stat_wei_bursts", stat_wei_bursts, 32'd32);
        check_output("t6_stat_ftm_bursts", stat_ftm_bursts, 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
